// File: rtl/hdlc_pkg.sv
// ============================================================================
//  Module      : hdlc_pkg
//  Description : Shared HDLC types and constants for the Tx framer and Rx path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hdlc_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START_FLAG = 3'd1,
      DATA       = 3'd2,
      FCS        = 3'd3,
      END_FLAG   = 3'd4,
      ABORT      = 3'd5
   } tx_state_t;

   localparam logic [7:0]  HDLC_FLAG    = 8'h7E;
   localparam logic [7:0]  HDLC_ABORT   = 8'hFE;
   localparam logic [15:0] CRC_POLY_REF = 16'h8408;
   localparam logic [15:0] CRC_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC_XOROUT   = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/hdlc_crc16_serial.sv
// ============================================================================
//  Module      : hdlc_crc16_serial
//  Description : Bit-serial reflected CRC-16/X.25 (raw register, no final XOR).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdlc_crc16_serial
   import hdlc_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst,
   input  logic        clear,
   input  logic        enable,
   input  logic        bit_in,
   output logic [15:0] crc_out
);

   logic [15:0] r_crc;

   always_ff @(posedge Clk) begin
      if (Rst || clear) begin
         r_crc <= CRC_INIT;
      end else if (enable) begin
         r_crc <= (r_crc >> 1) ^ ((r_crc[0] ^ bit_in) ? CRC_POLY_REF : 16'h0000);
      end
   end

   assign crc_out = r_crc;

endmodule

`default_nettype wire

// File: rtl/hdlc_tx_framer.sv
// ============================================================================
//  Module      : hdlc_tx_framer
//  Description : Serial HDLC transmit framer with zero-bit insertion and abort.
//                FCS generation is built only when HDLC_TX_FCS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdlc_tx_framer
   import hdlc_pkg::*;
#(
   parameter logic [7:0] FLAG_BYTE     = HDLC_FLAG,
   parameter logic [7:0] ABORT_BYTE    = HDLC_ABORT,
   parameter int         MAX_STUFF_RUN = 5
)(
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Tx_Start,
   input  logic [7:0] Tx_Data,
   input  logic       Tx_DataValid,
   input  logic       Tx_DataLast,
   output logic       Tx_DataReady,
   input  logic       Tx_AbortReq,
   output logic       Tx,
   output logic       Tx_ValidFrame,
   output logic       Tx_AbortedTrans,
   output logic       Tx_Done
);

   tx_state_t   r_state;
   logic [3:0]  r_bitCnt;
   logic [15:0] r_shift;      // bit currently on Tx sits in r_shift[0]
   logic [2:0]  r_ones;
   logic        r_lastByte;
   logic        r_tx;
   logic        r_validFrame;
   logic        r_done;
   logic        r_aborted;

   logic       w_stuff;
   logic       w_toAbort;
   logic       w_load;
   logic [2:0] w_nextOnes;
   logic [3:0] w_lastIdx;

   assign w_stuff    = (r_ones == 3'(MAX_STUFF_RUN));
   assign w_nextOnes = r_shift[1] ? (r_ones + 3'd1) : 3'd0;
   assign w_lastIdx  = (r_state == FCS) ? 4'd15 : 4'd7;

   assign Tx_DataReady = ((r_state == START_FLAG) && (r_bitCnt == 4'd7)) ||
                         ((r_state == DATA) && (r_bitCnt == 4'd7) && !w_stuff && !r_lastByte);

   assign w_load    = Tx_DataReady && Tx_DataValid;
   assign w_toAbort = (Tx_AbortReq && ((r_state == START_FLAG) || (r_state == DATA) || (r_state == FCS))) ||
                      (Tx_DataReady && !Tx_DataValid);

`ifdef HDLC_TX_FCS_EN
   logic        w_crcClear;
   logic        w_crcEn;
   logic        w_crcBit;
   logic [15:0] w_crc;
   logic [15:0] w_fcs;

   // CRC advances on the edge that places a new (unstuffed) payload bit on Tx.
   always_comb begin
      w_crcEn  = 1'b0;
      w_crcBit = 1'b0;
      if (w_load) begin
         w_crcEn  = 1'b1;
         w_crcBit = Tx_Data[0];
      end else if ((r_state == DATA) && !w_stuff && (r_bitCnt != 4'd7)) begin
         w_crcEn  = 1'b1;
         w_crcBit = r_shift[1];
      end
   end

   assign w_crcClear = (r_state == IDLE);
   assign w_fcs      = w_crc ^ CRC_XOROUT;

   hdlc_crc16_serial u_crc (
      .Clk     (Clk),
      .Rst     (Rst),
      .clear   (w_crcClear),
      .enable  (w_crcEn),
      .bit_in  (w_crcBit),
      .crc_out (w_crc)
   );
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state      <= IDLE;
         r_bitCnt     <= 4'd0;
         r_shift      <= 16'h0000;
         r_ones       <= 3'd0;
         r_lastByte   <= 1'b0;
         r_tx         <= 1'b1;
         r_validFrame <= 1'b0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         if (w_toAbort) begin
            r_state      <= ABORT;
            r_shift      <= {8'h00, ABORT_BYTE};
            r_tx         <= ABORT_BYTE[0];
            r_bitCnt     <= 4'd0;
            r_ones       <= 3'd0;
            r_validFrame <= 1'b0;
         end else if (w_load) begin
            r_state      <= DATA;
            r_shift      <= {8'h00, Tx_Data};
            r_tx         <= Tx_Data[0];
            r_bitCnt     <= 4'd0;
            r_ones       <= Tx_Data[0] ? (r_ones + 3'd1) : 3'd0;
            r_lastByte   <= Tx_DataLast;
            r_validFrame <= 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  r_tx         <= 1'b1;
                  r_validFrame <= 1'b0;
                  if (Tx_Start) begin
                     r_state    <= START_FLAG;
                     r_shift    <= {8'h00, FLAG_BYTE};
                     r_tx       <= FLAG_BYTE[0];
                     r_bitCnt   <= 4'd0;
                     r_ones     <= 3'd0;
                     r_lastByte <= 1'b0;
                  end
               end
               START_FLAG, END_FLAG, ABORT: begin
                  if (r_bitCnt != 4'd7) begin
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                     r_bitCnt  <= r_bitCnt + 4'd1;
                     r_done    <= (r_state == END_FLAG) && (r_bitCnt == 4'd6);
                     r_aborted <= (r_state == ABORT) && (r_bitCnt == 4'd6);
                  end else begin
                     r_state <= IDLE;
                     r_tx    <= 1'b1;
                  end
               end
               DATA, FCS: begin
                  if (w_stuff) begin
                     r_tx   <= 1'b0;
                     r_ones <= 3'd0;
                  end else if (r_bitCnt != w_lastIdx) begin
                     r_shift  <= r_shift >> 1;
                     r_tx     <= r_shift[1];
                     r_bitCnt <= r_bitCnt + 4'd1;
                     r_ones   <= w_nextOnes;
`ifdef HDLC_TX_FCS_EN
                  end else if (r_state == DATA) begin
                     r_state  <= FCS;
                     r_shift  <= w_fcs;
                     r_tx     <= w_fcs[0];
                     r_bitCnt <= 4'd0;
                     r_ones   <= w_fcs[0] ? (r_ones + 3'd1) : 3'd0;
`endif
                  end else begin
                     r_state      <= END_FLAG;
                     r_shift      <= {8'h00, FLAG_BYTE};
                     r_tx         <= FLAG_BYTE[0];
                     r_bitCnt     <= 4'd0;
                     r_ones       <= 3'd0;
                     r_validFrame <= 1'b0;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_tx    <= 1'b1;
               end
            endcase
         end
      end
   end

   assign Tx              = r_tx;
   assign Tx_ValidFrame   = r_validFrame;
   assign Tx_Done         = r_done;
   assign Tx_AbortedTrans = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_hdlc_tx_framer.sv
// ============================================================================
//  Module      : tb_hdlc_tx_framer
//  Description : Self-checking bench for hdlc_tx_framer against a frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hdlc_tx_framer;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       Tx_Start = 1'b0;
   logic [7:0] Tx_Data = 8'h00;
   logic       Tx_DataValid = 1'b0;
   logic       Tx_DataLast = 1'b0;
   logic       Tx_DataReady;
   logic       Tx_AbortReq = 1'b0;
   logic       Tx;
   logic       Tx_ValidFrame;
   logic       Tx_AbortedTrans;
   logic       Tx_Done;

   always #5 Clk = ~Clk;

   hdlc_tx_framer dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .Tx_Start        (Tx_Start),
      .Tx_Data         (Tx_Data),
      .Tx_DataValid    (Tx_DataValid),
      .Tx_DataLast     (Tx_DataLast),
      .Tx_DataReady    (Tx_DataReady),
      .Tx_AbortReq     (Tx_AbortReq),
      .Tx              (Tx),
      .Tx_ValidFrame   (Tx_ValidFrame),
      .Tx_AbortedTrans (Tx_AbortedTrans),
      .Tx_Done         (Tx_Done)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] pay [0:15];
   int payLen = 0;
   int underIdx = -1;
   int idx = 0;
   string tag = "";

   // expected per-cycle outputs, index 0 = first start-flag bit
   bit expTx[$];
   bit expVf[$];
   bit expDn[$];
   bit expAb[$];

   // byte source: supplies payload in order, withholds byte underIdx
   always @(posedge Clk) begin
      if (Tx_Start) idx <= 0;
      else if (Tx_DataValid && Tx_DataReady) idx <= idx + 1;
   end

   always @(negedge Clk) begin
      Tx_DataValid = (idx < payLen) && (idx != underIdx);
      Tx_Data      = pay[idx[3:0]];
      Tx_DataLast  = (idx == payLen - 1);
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] model_fcs();
      logic [15:0] crc = 16'hFFFF;
      for (int b = 0; b < payLen; b++) begin
         crc ^= {8'h00, pay[b]};
         for (int k = 0; k < 8; k++)
            crc = crc[0] ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
      end
      return crc ^ 16'hFFFF;
   endfunction

   task automatic push(input bit t, input bit v, input bit d, input bit a);
      expTx.push_back(t); expVf.push_back(v); expDn.push_back(d); expAb.push_back(a);
   endtask

   task automatic add_bit(input bit x, inout int ones);
      push(x, 1'b1, 1'b0, 1'b0);
      ones = x ? ones + 1 : 0;
      if (ones == 5) begin
         push(1'b0, 1'b1, 1'b0, 1'b0);
         ones = 0;
      end
   endtask

   // mode 0: normal, 1: abort requested while stream index arg is on Tx,
   // 2: byte arg never offered (underrun)
   task automatic build(input int mode, input int arg);
      logic [7:0] flag = 8'h7E;
      logic [7:0] abrt = 8'hFE;
      logic [15:0] fcs;
      int ones = 0;
      int byteEnd[$];
      expTx.delete(); expVf.delete(); expDn.delete(); expAb.delete();
      for (int i = 0; i < 8; i++) push(flag[i], 1'b0, 1'b0, 1'b0);
      for (int b = 0; b < payLen; b++) begin
         for (int i = 0; i < 8; i++) add_bit(pay[b][i], ones);
         byteEnd.push_back(expTx.size());
      end
`ifdef HDLC_TX_FCS_EN
      fcs = model_fcs();
      for (int i = 0; i < 16; i++) add_bit(fcs[i], ones);
`else
      fcs = 16'h0000;
`endif
      if (mode == 1) begin
         while (expTx.size() > arg + 1) begin
            void'(expTx.pop_back()); void'(expVf.pop_back());
            void'(expDn.pop_back()); void'(expAb.pop_back());
         end
      end else if (mode == 2) begin
         while (expTx.size() > byteEnd[arg-1]) begin
            void'(expTx.pop_back()); void'(expVf.pop_back());
            void'(expDn.pop_back()); void'(expAb.pop_back());
         end
      end
      if (mode == 0) for (int i = 0; i < 8; i++) push(flag[i], 1'b0, i == 7, 1'b0);
      else           for (int i = 0; i < 8; i++) push(abrt[i], 1'b0, 1'b0, i == 7);
      for (int i = 0; i < 10; i++) push(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_frame(input int mode, input int arg, input int cutAt, input bit abortWithStart);
      int n;
      build(mode, arg);
      underIdx = (mode == 2) ? arg : -1;
      @(negedge Clk);
      Tx_Start = 1'b1;
      Tx_AbortReq = abortWithStart;
      @(negedge Clk);
      Tx_Start = 1'b0;
      Tx_AbortReq = 1'b0;
      n = (cutAt >= 0) ? cutAt : expTx.size();
      for (int i = 0; i < n; i++) begin
         cmp($sformatf("%s cyc%0d {Tx,Valid,Done,Abort}", tag, i),
             {28'h0, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans},
             {28'h0, expTx[i], expVf[i], expDn[i], expAb[i]});
         Tx_AbortReq = (mode == 1) && (i == arg);
         @(negedge Clk);
      end
      Tx_AbortReq = 1'b0;
   endtask

   initial begin
      logic [23:0] v;
      repeat (3) @(negedge Clk);
      cmp("reset {Tx,Valid,Ready,Done,Abort}",
          {27'h0, Tx, Tx_ValidFrame, Tx_DataReady, Tx_Done, Tx_AbortedTrans}, 32'h10);
      Rst = 1'b0;

      // model pins: flag + 0x01 (+ end flag when no FCS), LSB first
      pay[0] = 8'h01; payLen = 1;
      build(0, 0);
      v = '0;
      for (int i = 0; i < 24; i++) v[i] = expTx[i];
`ifdef HDLC_TX_FCS_EN
      cmp("pin frame01 bits", {16'h0, v[15:0]}, 32'h017E);
`else
      cmp("pin frame01 bits", {8'h0, v}, 32'h7E017E);
`endif
      pay[0] = 8'hFF;
      build(0, 0);
      v = '0;
      for (int i = 0; i < 9; i++) v[i] = expTx[8 + i];
      cmp("pin frameFF payload bits", {23'h0, v[8:0]}, 32'h1DF);
`ifdef HDLC_TX_FCS_EN
      for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
      payLen = 9;
      cmp("pin fcs 123456789", {16'h0, model_fcs()}, 32'h906E);
`endif

      // start with simultaneous abort request in IDLE: start wins
      tag = "frame01"; pay[0] = 8'h01; payLen = 1;
      run_frame(0, 0, -1, 1'b1);

      tag = "frameFF"; pay[0] = 8'hFF; payLen = 1;
      run_frame(0, 0, -1, 1'b0);

      tag = "ascii9";
      for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
      payLen = 9;
      run_frame(0, 0, -1, 1'b0);

      // runs of ones crossing byte boundaries
      tag = "stuffx";
      pay[0] = 8'h7E; pay[1] = 8'hF8; pay[2] = 8'h1F; pay[3] = 8'hFF; payLen = 4;
      run_frame(0, 0, -1, 1'b0);

      // index 26 = flag(8) + two bytes(16) + bit 2 of third byte, no stuffing
      tag = "abort3";
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44; payLen = 4;
      run_frame(1, 26, -1, 1'b0);

      tag = "underrun";
      pay[0] = 8'hF8; pay[1] = 8'h5A; pay[2] = 8'h3C; payLen = 3;
      run_frame(2, 1, -1, 1'b0);

      tag = "rstmid";
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; payLen = 3;
      run_frame(0, 0, 15, 1'b0);
      Rst = 1'b1;
      @(negedge Clk);
      cmp("rstmid {Tx,Valid,Ready,Done,Abort}",
          {27'h0, Tx, Tx_ValidFrame, Tx_DataReady, Tx_Done, Tx_AbortedTrans}, 32'h10);
      Rst = 1'b0;
      tag = "afterrst";
      run_frame(0, 0, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
